// File: rtl/program_counter.sv
// ---------------------------------------------------------------------------
// program_counter
// Fetch-address generator for the 8-bit single-cycle datapath. Holds the PC
// and picks its next value each cycle: increment, PC-relative branch,
// absolute jump, stall or halt. A small BOOT/RUN/HALT FSM gates fetches.
//
// Parameters:
//   RESET_PC      PC value loaded on reset
// Ports:
//   clock         rising-edge clock
//   reset         asynchronous active-low reset
//   stall         hold PC and state this cycle
//   branch, zero  conditional branch and its condition flag
//   branch_offset 8-bit two's complement offset (relative to pc + 1)
//   jump          absolute jump to jump_target
//   halt, resume  enter / leave HALT
//   pc            current fetch address (registered)
//   fetch_valid   pc addresses a real instruction (RUN only)
//   halted        FSM is in HALT
//   branch_count  saturating count of taken redirects (PC_BRANCH_COUNTER_EN)
//   taken         a branch or jump redirected the PC on the last edge
//
// Optional feature macro: PC_BRANCH_COUNTER_EN adds the branch_count output.
// ---------------------------------------------------------------------------
module program_counter #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       stall,
  input  logic       branch,
  input  logic       zero,
  input  logic [7:0] branch_offset,
  input  logic       jump,
  input  logic [7:0] jump_target,
  input  logic       halt,
  input  logic       resume,
  output logic [7:0] pc,
  output logic       fetch_valid,
  output logic       halted,
`ifdef PC_BRANCH_COUNTER_EN
  output logic [7:0] branch_count,
`endif
  output logic       taken
);

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  logic [1:0] r_state;
  logic [7:0] r_pc;
  logic       r_taken;

  logic [1:0] w_state_next;
  logic [7:0] w_pc_next;
  logic [7:0] w_pc_inc;
  logic       w_taken_next;

  assign w_pc_inc = r_pc + 8'd1;

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_taken_next = 1'b0;
    case (r_state)
      ST_BOOT: begin
        // One dead cycle after reset; all control inputs are ignored.
        w_state_next = ST_RUN;
      end
      ST_RUN: begin
        if (!stall) begin
          if (halt) begin
            w_state_next = ST_HALT;
          end else if (jump) begin
            w_pc_next    = jump_target;
            w_taken_next = 1'b1;
          end else if (branch && zero) begin
            // Offset is relative to the sequential successor; wraps mod 256.
            w_pc_next    = w_pc_inc + branch_offset;
            w_taken_next = 1'b1;
          end else begin
            w_pc_next = w_pc_inc;
          end
        end
      end
      ST_HALT: begin
        if (!stall && resume) begin
          w_pc_next    = w_pc_inc;
          w_state_next = ST_RUN;
        end
      end
      default: begin
        w_state_next = ST_BOOT;
        w_pc_next    = RESET_PC;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_BOOT;
      r_pc    <= RESET_PC;
      r_taken <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_taken <= w_taken_next;
    end
  end

`ifdef PC_BRANCH_COUNTER_EN
  logic [7:0] r_branch_count;

  // Only RUN without stall can redirect, so stall holds the count for free.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_branch_count <= 8'h00;
    end else if (w_taken_next && (r_branch_count != 8'hFF)) begin
      r_branch_count <= r_branch_count + 8'd1;
    end
  end

  assign branch_count = r_branch_count;
`endif

  assign pc          = r_pc;
  assign taken       = r_taken;
  assign fetch_valid = (r_state == ST_RUN);
  assign halted      = (r_state == ST_HALT);

endmodule
